blk_5b0d0b: RTL

//  Per-process deadlock monitor for the HLS dataflow regions of the echo server.

---
 rtl/echo_server_application_hls_dl_pkg.sv | 16 +
 rtl/echo_server_application_hls_dl_persist_filter.sv | 84 ++++++++
 rtl/blk_5b0d0b.sv | 110 +++++++++++
 3 files changed

// File: rtl/echo_server_application_hls_dl_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
//   dl_state_t  : persistence FSM state encoding
//   calc_cnt_w  : width of a counter that holds 0..persist
package echo_server_application_hls_dl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SUSPECT  = 2'b01,
    DETECTED = 2'b10
  } dl_state_t;

  function automatic int calc_cnt_w(input int persist);
    return $clog2(persist + 1);
  endfunction

endpackage

// File: rtl/echo_server_application_hls_dl_persist_filter.sv
// Persistence filter: asserts 'detected' only after 'cand' has been high
// for PERSIST_CYCLES consecutive cycles; drops one cycle after 'cand' falls.
// Ports:
//   clock, reset (async, active-low)
//   cand            : deadlock candidate this cycle
//   detected        : state == DETECTED (state-register decode)
//   enter_detected  : next edge moves the FSM into DETECTED
module echo_server_application_hls_dl_persist_filter
  import echo_server_application_hls_dl_pkg::*;
#(
  parameter int PERSIST_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic cand,
  output logic detected,
  output logic enter_detected
);

  localparam int              CNT_W    = calc_cnt_w(PERSIST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dl_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // r_cnt = number of consecutive cand cycles already seen; it stops
  // at PERSIST_CYCLES once DETECTED is reached (held, never wraps).
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    enter_detected = 1'b0;
    case (r_state)
      IDLE: begin
        if (cand) begin
          w_cnt_nxt = CNT_ONE;
          if (PERSIST_CYCLES == 1) begin
            w_state_nxt    = DETECTED;
            enter_detected = 1'b1;
          end else begin
            w_state_nxt = SUSPECT;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      SUSPECT: begin
        if (!cand) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt    = DETECTED;
            enter_detected = 1'b1;
          end
        end
      end
      DETECTED: begin
        if (!cand) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign detected = (r_state == DETECTED);

endmodule

// File: rtl/blk_5b0d0b.sv
// Per-process deadlock monitor for HLS dataflow regions (one per process).
// Merges incoming dependency sets, forwards its own set downstream, filters
// cyclic-dependency candidates for persistence and drives the report token ring.
// Optional feature macro: ECHO_SERVER_DL_SNAPSHOT_EN (dl_cycle_out snapshot;
// when undefined dl_cycle_out is tied to 0).
// Ports:
//   clock, reset (async, active-low)
//   proc_dep_vld_vec     : process blocked on out channel i
//   in_chan_dep_vld_vec  : in-channel dependency valid
//   in_chan_dep_data_vec : dependency set per in-channel (i*PROC_NUM +: PROC_NUM)
//   token_in_vec, dl_detect_in, origin, token_clear : token ring / global flag
//   out_chan_dep_vld_vec : pass-through of proc_dep_vld_vec
//   out_chan_dep_data    : own dependency set incl. self bit
//   token_out_vec        : registered token forward
//   dl_detect_out        : persistence-filtered deadlock flag
//   dl_cycle_out         : snapshot of processes in the cycle
module blk_5b0d0b
  import echo_server_application_hls_dl_pkg::*;
#(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID        = 0,
  parameter int IN_CHAN_NUM    = 2,
  parameter int OUT_CHAN_NUM   = 3,
  parameter int PERSIST_CYCLES = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic [PROC_NUM-1:0]             dl_cycle_out
);

  localparam logic [PROC_NUM-1:0] SELF = PROC_NUM'(1) << PROC_ID;

  logic [PROC_NUM-1:0]     w_dep_comb, w_dep_sel, r_dep_reg;
  logic [OUT_CHAN_NUM-1:0] r_token_out;
  logic                    w_gate, w_blocked, w_cand, w_tok_fwd;
  logic                    w_detected, w_enter;

  always_comb begin
    w_dep_comb = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++)
      w_dep_comb |= {PROC_NUM{in_chan_dep_vld_vec[i]}} &
                    in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
  end

  // Once a deadlock is already flagged globally, only a token arrival lets
  // fresh dependency information in; otherwise the last set is held.
  assign w_gate    = ~dl_detect_in | (|token_in_vec);
  assign w_dep_sel = w_gate ? w_dep_comb : r_dep_reg;
  assign w_blocked = |proc_dep_vld_vec;
  assign w_cand    = w_gate & w_dep_sel[PROC_ID] & w_blocked;
  // origin wins over token_clear
  assign w_tok_fwd = ((|token_in_vec) & ~token_clear) | origin;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dep_reg   <= '0;
      r_token_out <= '0;
    end else begin
      r_dep_reg   <= w_blocked ? w_dep_sel : '0;
      r_token_out <= w_tok_fwd ? proc_dep_vld_vec : '0;
    end
  end

  echo_server_application_hls_dl_persist_filter #(
    .PERSIST_CYCLES (PERSIST_CYCLES)
  ) u_persist (
    .clock          (clock),
    .reset          (reset),
    .cand           (w_cand),
    .detected       (w_detected),
`ifdef ECHO_SERVER_DL_SNAPSHOT_EN
    .enter_detected (w_enter)
`else
    .enter_detected ()
`endif
  );

`ifdef ECHO_SERVER_DL_SNAPSHOT_EN
  logic [PROC_NUM-1:0] r_dl_cycle;

  // Capture on entry, hold while DETECTED, clear on the exit edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     r_dl_cycle <= '0;
    else if (w_enter)               r_dl_cycle <= w_dep_sel;
    else if (w_detected && !w_cand) r_dl_cycle <= '0;
  end

  assign dl_cycle_out = r_dl_cycle;
`else
  assign w_enter      = 1'b0;
  assign dl_cycle_out = '0;
`endif

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = r_dep_reg | SELF;
  assign token_out_vec        = r_token_out;
  assign dl_detect_out        = w_detected;

endmodule
